mem_port_arbiter: RTL

Shares the CPU's single memory port between the instruction-fetch requester and the data-access requester in the multi-cycle datapath. Each requester gets a hold-until-done request/done handshake. The block grants one requester at a time and drives `readM`/`writeM`/`address`/`data` for a fixed access latency. It captures read data and returns it with a one-cycle done pulse. It sits between the CPU's state sequencer and the external memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared state and owner encodings for the memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  // Which requester currently owns (or last owned) the memory port.
  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } arb_owner_e;

  // Access counter width; holds MEM_LATENCY-1 for latencies up to 15.
  localparam int unsigned CntWidth = 4;

  // The requester that is not `o`.
  function automatic arb_owner_e other_owner(arb_owner_e o);
    return (o == OwnI) ? OwnD : OwnI;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester not
// granted last time wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_e last,
  output logic       gnt_valid,
  output arb_owner_e gnt_owner
);

  // Pick a winner among the live requests.
  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_owner = OwnI;
    if (req_i && req_d) begin
      gnt_owner = other_owner(last);
    end else if (req_d) begin
      gnt_owner = OwnD;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access.
// One requester is served at a time; each access holds its strobe for
// MEM_LATENCY cycles and finishes with a one-cycle done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy
);

  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(MEM_LATENCY - 1);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q, last_q;
  logic                 we_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [WORD_SIZE-1:0] i_rdata_q, d_rdata_q;

  logic       gnt_valid;
  arb_owner_e gnt_owner;
  logic       grant;
  logic       acc_is_write;

  rr_pick2 u_pick (
    .req_i     (i_req),
    .req_d     (d_req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  assign grant        = (state_q == StIdle) && gnt_valid;
  assign acc_is_write = (owner_q == OwnD) && we_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (gnt_valid) state_d = StAcc;
      StAcc:  if (cnt_q == '0) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs: strobes and address only during ACC, done only in RESP.
  always_comb begin
    readM   = 1'b0;
    writeM  = 1'b0;
    address = '0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    unique case (state_q)
      StAcc: begin
        address = addr_q;
        if (acc_is_write) begin
          writeM = 1'b1;
        end else begin
          readM = 1'b1;
        end
      end
      StResp: begin
        i_done = (owner_q == OwnI);
        d_done = (owner_q == OwnD);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign data    = writeM ? wdata_q : {WORD_SIZE{1'bz}};
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  // Grant latches, access counter and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OwnI;
      last_q    <= OwnI;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (grant) begin
      owner_q <= gnt_owner;
      last_q  <= gnt_owner;
      we_q    <= (gnt_owner == OwnD) && d_we;
      addr_q  <= (gnt_owner == OwnD) ? d_addr : i_addr;
      wdata_q <= d_wdata;
      cnt_q   <= CntLoad;
    end else if (state_q == StAcc) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end else if (!acc_is_write) begin
        // Last strobe cycle: memory data is valid on the bus now.
        if (owner_q == OwnI) begin
          i_rdata_q <= data;
        end else begin
          d_rdata_q <= data;
        end
      end
    end
  end

endmodule
